max_finder: RTL

MAX_FINDER -- requirements
Module: max_finder

---
 rtl/max_finder.sv | 88 ++++++++
 1 files changed

// File: rtl/max_finder.sv
// rtl/max_finder.sv - frame maximum finder with first-occurrence index and duplicate count
module max_finder #(
   parameter int W = 4,
   parameter int N = 8,
   localparam int IW = $clog2(N)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          in_valid,
   input  logic [W-1:0]  in_data,
   output logic          in_ready,
   output logic          busy,
   output logic          done,
   output logic [W-1:0]  max_out,
   output logic [IW-1:0] max_idx,
   output logic [IW:0]   dup_cnt
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state_q;
   logic [W-1:0]  max_q;
   logic [IW-1:0] idx_q;
   logic [IW:0]   dup_q;
   logic [IW-1:0] cnt_q;
   logic [IW-1:0] cnt_d;

   assign cnt_d = cnt_q + IW'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         max_q   <= '0;
         idx_q   <= '0;
         dup_q   <= '0;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q <= RUN;
                  max_q   <= '0;
                  idx_q   <= '0;
                  dup_q   <= '0;
                  cnt_q   <= '0;
               end
            end
            RUN: begin
               if (in_valid) begin
                  // The first sample always seeds the result, even when it is zero.
                  if (cnt_q == '0 || in_data > max_q) begin
                     max_q <= in_data;
                     idx_q <= cnt_q;
                     dup_q <= (IW+1)'(1);
                  end else if (in_data == max_q) begin
                     dup_q <= dup_q + (IW+1)'(1);
                  end
                  if (cnt_q == IW'(N-1)) begin
                     state_q <= DONE;
                  end else begin
                     cnt_q <= cnt_d;
                  end
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   // Handshake and status are pure state decodes, so no input reaches an output combinationally.
   assign in_ready = (state_q == RUN);
   assign busy     = (state_q == RUN);
   assign done     = (state_q == DONE);
   assign max_out  = max_q;
   assign max_idx  = idx_q;
   assign dup_cnt  = dup_q;

endmodule
